// File: rtl/branch_pred_pkg.sv
// Shared definitions for the branch predictor slice.
//   - BEQ/BNE opcode constants
//   - forwarding-select encoding for the ID-stage operand muxes
//   - 2-bit saturating counter type, its default reset value and inc/dec helpers
package branch_pred_pkg;

  localparam logic [5:0] BEQ = 6'h04;
  localparam logic [5:0] BNE = 6'h05;

  // 2'b11 is left unnamed: it selects the register file value, same as FWD_REG.
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_INIT_DEFAULT = 2'b01;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == 2'b11) ? c : ctr_t'(c + 2'b01);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == 2'b00) ? c : ctr_t'(c - 2'b01);
  endfunction

endpackage

// File: rtl/branch_operand_mux.sv
// ID-stage forwarding mux for one branch comparison operand.
//   sel          in  2       forwarding select (00/11 reg, 01 MEM/WB, 10 EX/MEM)
//   reg_val      in  DATA_W  register file output
//   memwb_value  in  DATA_W  MEM/WB forward value
//   exmem_aluout in  DATA_W  EX/MEM forward value
//   operand      out DATA_W  selected operand
module branch_operand_mux
  import branch_pred_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] reg_val,
  input  logic [DATA_W-1:0] memwb_value,
  input  logic [DATA_W-1:0] exmem_aluout,
  output logic [DATA_W-1:0] operand
);

  always_comb begin
    operand = reg_val;
    case (fwd_sel_t'(sel))
      FWD_MEMWB: operand = memwb_value;
      FWD_EXMEM: operand = exmem_aluout;
      default:   operand = reg_val;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Branch predictor and ID-stage BEQ/BNE resolver.
// Fetch side: PC-indexed table of 2-bit saturating counters, optional BTB
// (enabled by defining BRANCH_PREDICTOR_BTB_EN).
// ID side: forwarded operand compare, mispredict flag, redirect PC, table
// training and a saturating mispredict counter.
// Ports:
//   clock, reset                       clock / async active-high reset
//   if_pc -> pred_taken, pred_hit, pred_target   fetch-stage prediction
//   id_valid, id_op, id_pc, id_target, id_pred_taken   ID-stage branch info
//   fa, fb, reg_a, reg_b, memwb_value, exmem_aluout    operand forwarding
//   takebranch, mispredict, redirect_pc, mispredict_count   resolution outputs
module branch_predictor
  import branch_pred_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned IDX_W    = 6,
  parameter ctr_t        CTR_INIT = CTR_INIT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic              pred_hit,
  output logic [PC_W-1:0]   pred_target,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [PC_W-1:0]   id_target,
  input  logic              id_pred_taken,
  input  logic [1:0]        fa,
  input  logic [1:0]        fb,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] reg_b,
  input  logic [DATA_W-1:0] memwb_value,
  input  logic [DATA_W-1:0] exmem_aluout,
  output logic              takebranch,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [15:0]       mispredict_count
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  logic [IDX_W-1:0]  if_idx;
  logic [IDX_W-1:0]  id_idx;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              resolved;
  logic              dir_wrong;
  logic              btb_wrong;
  logic [15:0]       cnt;
  ctr_t              ctr [DEPTH];

  assign if_idx = if_pc[IDX_W+1:2];
  assign id_idx = id_pc[IDX_W+1:2];

  branch_operand_mux #(.DATA_W(DATA_W)) u_mux_a (
    .sel          (fa),
    .reg_val      (reg_a),
    .memwb_value  (memwb_value),
    .exmem_aluout (exmem_aluout),
    .operand      (op_a)
  );

  branch_operand_mux #(.DATA_W(DATA_W)) u_mux_b (
    .sel          (fb),
    .reg_val      (reg_b),
    .memwb_value  (memwb_value),
    .exmem_aluout (exmem_aluout),
    .operand      (op_b)
  );

  always_comb begin
    resolved   = 1'b0;
    takebranch = 1'b0;
    if (id_valid) begin
      if (id_op == BEQ) begin
        resolved   = 1'b1;
        takebranch = (op_a == op_b);
      end else if (id_op == BNE) begin
        resolved   = 1'b1;
        takebranch = (op_a != op_b);
      end
    end
  end

  assign redirect_pc = takebranch ? id_target : id_pc + PC_W'(4);
  assign dir_wrong   = takebranch != id_pred_taken;
  assign mispredict  = resolved & (dir_wrong | btb_wrong);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctr <= '{default: CTR_INIT};
    end else if (resolved) begin
      ctr[id_idx] <= takebranch ? ctr_inc(ctr[id_idx]) : ctr_dec(ctr[id_idx]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (mispredict && cnt != '1) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign mispredict_count = cnt;

`ifdef BRANCH_PREDICTOR_BTB_EN
  logic [DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0] btb_tag    [DEPTH];
  logic [PC_W-1:0]  btb_target [DEPTH];
  logic             id_match;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btb_valid  <= '0;
      btb_tag    <= '{default: '0};
      btb_target <= '{default: '0};
    end else if (resolved && takebranch) begin
      btb_valid[id_idx]  <= 1'b1;
      btb_tag[id_idx]    <= id_pc[PC_W-1:IDX_W+2];
      btb_target[id_idx] <= id_target;
    end
  end

  assign pred_hit    = btb_valid[if_idx] && (btb_tag[if_idx] == if_pc[PC_W-1:IDX_W+2]);
  assign pred_target = btb_target[if_idx];
  assign pred_taken  = ctr[if_idx][1] & pred_hit;

  // A taken branch with no matching target entry fetched the wrong path
  // even when the direction guess was right.
  assign id_match  = btb_valid[id_idx] && (btb_tag[id_idx] == id_pc[PC_W-1:IDX_W+2])
                     && (btb_target[id_idx] == id_target);
  assign btb_wrong = takebranch & ~id_match;

  logic [1:0] unused_if_pc;
  assign unused_if_pc = if_pc[1:0];
`else
  assign pred_hit    = 1'b0;
  assign pred_target = '0;
  assign pred_taken  = ctr[if_idx][1];
  assign btb_wrong   = 1'b0;

  logic [TAG_W+1:0] unused_if_pc;
  assign unused_if_pc = {if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

`ifdef BRANCH_PREDICTOR_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  localparam int S_PTAKEN = 0, S_PHIT = 1, S_PTGT = 2, S_TAKE = 3,
                 S_MISP = 4, S_REDIR = 5, S_CNT = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken, pred_hit;
  logic [31:0] pred_target;
  logic        id_valid;
  logic [5:0]  id_op;
  logic [31:0] id_pc, id_target;
  logic        id_pred_taken;
  logic [1:0]  fa, fb;
  logic [31:0] reg_a, reg_b, memwb_value, exmem_aluout;
  logic        takebranch, mispredict;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_count;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } item_t;

  item_t       sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned exp_cnt  = 0;

  branch_predictor #(
    .DATA_W   (32),
    .PC_W     (32),
    .IDX_W    (6),
    .CTR_INIT (2'b01)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_hit         (pred_hit),
    .pred_target      (pred_target),
    .id_valid         (id_valid),
    .id_op            (id_op),
    .id_pc            (id_pc),
    .id_target        (id_target),
    .id_pred_taken    (id_pred_taken),
    .fa               (fa),
    .fb               (fb),
    .reg_a            (reg_a),
    .reg_b            (reg_b),
    .memwb_value      (memwb_value),
    .exmem_aluout     (exmem_aluout),
    .takebranch       (takebranch),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .mispredict_count (mispredict_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] obs(input int s);
    case (s)
      S_PTAKEN: return {31'd0, pred_taken};
      S_PHIT:   return {31'd0, pred_hit};
      S_PTGT:   return pred_target;
      S_TAKE:   return {31'd0, takebranch};
      S_MISP:   return {31'd0, mispredict};
      S_REDIR:  return redirect_pc;
      default:  return {16'd0, mispredict_count};
    endcase
  endfunction

  task automatic push(input string name, input int sig, input logic [31:0] exp);
    item_t it;
    it.name = name;
    it.sig  = sig;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  task automatic check_all();
    item_t       it;
    logic [31:0] o;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      o  = obs(it.sig);
      n_assert++;
      assert (o === it.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", it.name, o, it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic pt, input logic [1:0] sa,
                       input logic [1:0] sb_, input logic [31:0] ra, input logic [31:0] rb,
                       input logic [31:0] mw, input logic [31:0] ex);
    id_valid = v; id_op = op; id_pc = pc; id_target = tgt; id_pred_taken = pt;
    fa = sa; fb = sb_; reg_a = ra; reg_b = rb; memwb_value = mw; exmem_aluout = ex;
  endtask

  task automatic idle();
    drive(1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    if_pc = 32'h40;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    push("rst_ptaken", S_PTAKEN, 32'd0);
    push("rst_phit",   S_PHIT,   32'd0);
    push("rst_ptgt",   S_PTGT,   32'd0);
    push("rst_cnt",    S_CNT,    32'd0);
    check_all();

    // BEQ taken at 0x40, predicted not-taken
    drive(1'b1, 6'h04, 32'h40, 32'h80, 1'b0, 2'b00, 2'b00, 32'd7, 32'd7, 32'd1, 32'd2);
    #1;
    push("beq_take",   S_TAKE,   32'd1);
    push("beq_misp",   S_MISP,   32'd1);
    push("beq_redir",  S_REDIR,  32'h80);
    push("beq_same_cycle_ptaken", S_PTAKEN, 32'd0);
    check_all();
    exp_cnt++;
    tick();
    idle();
    #1;
    push("trained_ptaken", S_PTAKEN, 32'd1);
    push("trained_phit",   S_PHIT,   {31'd0, BTB});
    push("trained_ptgt",   S_PTGT,   BTB ? 32'h80 : 32'h0);
    push("cnt_after_beq",  S_CNT,    exp_cnt);
    check_all();

    // BNE with forwarded equal operands: not taken
    drive(1'b1, 6'h05, 32'h100, 32'h200, 1'b0, 2'b10, 2'b01, 32'd1, 32'd2, 32'd5, 32'd5);
    #1;
    push("bne_take",  S_TAKE,  32'd0);
    push("bne_misp",  S_MISP,  32'd0);
    push("bne_redir", S_REDIR, 32'h104);
    check_all();
    tick();

    // Four taken at 0x40 (counter saturates at 11), then two not-taken
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'h04, 32'h40, 32'h80, 1'b1, 2'b00, 2'b00, 32'd3, 32'd3, 32'd0, 32'd0);
      tick();
    end
    drive(1'b1, 6'h04, 32'h40, 32'h80, 1'b1, 2'b00, 2'b00, 32'd3, 32'd4, 32'd0, 32'd0);
    #1;
    push("nt1_misp",  S_MISP,  32'd1);
    push("nt1_redir", S_REDIR, 32'h44);
    check_all();
    exp_cnt++;
    tick();
    #1;
    push("after_nt1_ptaken", S_PTAKEN, 32'd1);
    check_all();
    tick();
    exp_cnt++;
    #1;
    push("after_nt2_ptaken", S_PTAKEN, 32'd0);
    push("cnt_after_nt2",    S_CNT,    exp_cnt);
    check_all();

    // Non-branch opcode with equal operands: no resolution, no training
    drive(1'b1, 6'h00, 32'h40, 32'h80, 1'b0, 2'b00, 2'b00, 32'd9, 32'd9, 32'd0, 32'd0);
    #1;
    push("nop_take",  S_TAKE,  32'd0);
    push("nop_misp",  S_MISP,  32'd0);
    push("nop_redir", S_REDIR, 32'h44);
    check_all();
    tick();
    #1;
    push("nop_no_train", S_PTAKEN, 32'd0);
    check_all();

    // Select 11 falls back to the register value
    drive(1'b1, 6'h04, 32'h200, 32'h300, 1'b1, 2'b11, 2'b00, 32'd9, 32'd9, 32'd1, 32'd2);
    #1;
    push("sel11_take", S_TAKE, 32'd1);
    push("sel11_misp", S_MISP, {31'd0, BTB});
    check_all();
    exp_cnt += BTB;
    id_valid = 1'b0;
    #1;
    push("invalid_take", S_TAKE, 32'd0);
    push("invalid_misp", S_MISP, 32'd0);
    check_all();
    tick();

    // Redirect wraps at the top of the address space
    drive(1'b1, 6'h05, 32'hFFFF_FFFC, 32'h10, 1'b0, 2'b00, 2'b00, 32'd6, 32'd6, 32'd0, 32'd0);
    #1;
    push("wrap_redir", S_REDIR, 32'h0);
    push("wrap_misp",  S_MISP,  32'd0);
    check_all();
    tick();
    idle();
    #1;
    push("cnt_before_sat", S_CNT, exp_cnt);
    check_all();

    // Long run of mispredicts saturates the counter
    drive(1'b1, 6'h04, 32'h300, 32'h400, 1'b0, 2'b00, 2'b00, 32'd1, 32'd1, 32'd0, 32'd0);
    #1;
    push("sat_misp", S_MISP, 32'd1);
    check_all();
    repeat (65540) tick();
    #1;
    push("sat_cnt", S_CNT, 32'h0000_FFFF);
    check_all();
    if_pc = 32'h300;
    #1;
    push("pre_rst_ptaken", S_PTAKEN, 32'd1);
    check_all();

    // Reset between edges, with a resolving branch still presented
    reset = 1'b1;
    #1;
    push("midrst_cnt",    S_CNT,    32'd0);
    push("midrst_ptaken", S_PTAKEN, 32'd0);
    push("midrst_phit",   S_PHIT,   32'd0);
    push("midrst_take",   S_TAKE,   32'd1);
    push("midrst_redir",  S_REDIR,  32'h400);
    check_all();
    tick();
    push("rst_edge_cnt",    S_CNT,    32'd0);
    push("rst_edge_ptaken", S_PTAKEN, 32'd0);
    check_all();
    idle();
    reset = 1'b0;
    tick();
    push("post_rst_cnt",    S_CNT,    32'd0);
    push("post_rst_ptaken", S_PTAKEN, 32'd0);
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
